// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the banked single-port RAM wrapper.
// Imported by the wrapper and its bank cell.
package sp_ram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  // Which source drives the read data returned by the last read/bypass access.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_BYP  = 2'd2
  } rd_src_e;

  // Width of a bank index signal; never zero, even for a single bank.
  function automatic int unsigned bank_idx_width(input int unsigned num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/sp_ram_be_cell.sv
// One RAM bank: synchronous read with one cycle of latency and per-byte write enables.
// The read register only updates on read accesses, so it holds between reads.
module sp_ram_be_cell #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8192,
  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8,
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  wr,
  input  logic [BE_WIDTH-1:0]   be,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [BE_WIDTH-1:0][7:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0]    rdata_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      if (wr) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (be[b]) begin
            mem[addr][b] <= wdata[b*8 +: 8];
          end
        end
      end else begin
        rdata_reg <= mem[addr];
      end
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/sp_ram_banked_wrap.sv
// Word-interleaved banked single-port RAM with req/gnt/rvalid handshake,
// post-reset zero fill, optional output register and write-data bypass.
module sp_ram_banked_wrap
  import sp_ram_pkg::*;
#(
  parameter int unsigned NUM_WORDS     = 32768,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_BANKS     = 4,
  parameter int unsigned ADDR_WIDTH    = $clog2(NUM_WORDS),
  parameter int unsigned BE_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned OUT_REG       = 0,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  bypass_en_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  init_busy_o
);

  localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
  localparam int unsigned BANK_W    = bank_idx_width(NUM_BANKS);
  localparam int unsigned ROWS      = NUM_WORDS / NUM_BANKS;
  localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  if (NUM_WORDS % NUM_BANKS != 0) begin : g_err_words
    $error("NUM_WORDS must be a multiple of NUM_BANKS");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_err_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if ((NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_err_banks
    $error("NUM_BANKS must be a power of two");
  end

  // Low address bits pick the bank, the remaining upper bits the row.
  logic [BANK_W-1:0] bank_sel;
  logic [ROW_W-1:0]  row_sel;

  if (NUM_BANKS > 1) begin : g_bank_sel
    assign bank_sel = addr_i[BANK_BITS-1:0];
  end else begin : g_bank_sel_one
    assign bank_sel = '0;
  end

  if (ROWS > 1) begin : g_row_sel
    assign row_sel = addr_i[ADDR_WIDTH-1 -: ROW_W];
  end else begin : g_row_sel_one
    assign row_sel = '0;
  end

  ram_state_e       state_reg, state_next;
  logic [ROW_W-1:0] init_cnt_reg, init_cnt_next;
  logic             init_wr;
  logic             acc;
  logic             rd_acc;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      if (INIT_ON_RESET != 0) begin
        state_reg <= ST_INIT;
      end else begin
        state_reg <= ST_READY;
      end
      init_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    init_busy_o   = (state_reg == ST_INIT);
    // Nothing is accepted or written while reset is asserted.
    gnt_o         = (state_reg == ST_READY) && req_i && !rst_i;
    init_wr       = (state_reg == ST_INIT) && !rst_i;
    acc           = gnt_o;
    rd_acc        = gnt_o && (!we_i || bypass_en_i);
    if (state_reg == ST_INIT) begin
      if (init_cnt_reg == LAST_ROW) begin
        state_next    = ST_READY;
        init_cnt_next = '0;
      end else begin
        init_cnt_next = init_cnt_reg + 1'b1;
      end
    end
  end

  // Address, data and byte enables are shared; only the enable is per bank.
  logic                  cell_wr;
  logic [BE_WIDTH-1:0]   cell_be;
  logic [ROW_W-1:0]      cell_addr;
  logic [DATA_WIDTH-1:0] cell_wdata;
  logic [NUM_BANKS-1:0]  bank_en;
  logic [DATA_WIDTH-1:0] cell_rdata [NUM_BANKS];

  always_comb begin
    cell_wr    = we_i;
    cell_be    = be_i;
    cell_addr  = row_sel;
    cell_wdata = wdata_i;
    if (init_wr) begin
      cell_wr    = 1'b1;
      cell_be    = '1;
      cell_addr  = init_cnt_reg;
      cell_wdata = '0;
    end
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign bank_en[gi] = init_wr || (acc && !bypass_en_i && (bank_sel == BANK_W'(gi)));

    sp_ram_be_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (ROWS)
    ) u_cell (
      .clk   (clk),
      .en    (bank_en[gi]),
      .wr    (cell_wr),
      .be    (cell_be),
      .addr  (cell_addr),
      .wdata (cell_wdata),
      .rdata (cell_rdata[gi])
    );
  end

  // Read-side bookkeeping travels with the request; it only changes on a
  // returning access so the read mux output holds between reads.
  logic                  v1_reg;
  rd_src_e               src_reg;
  logic [BANK_W-1:0]     bank_reg;
  logic [DATA_WIDTH-1:0] byp_data_reg;
  logic [DATA_WIDTH-1:0] rd_data;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      v1_reg       <= 1'b0;
      src_reg      <= SRC_ZERO;
      bank_reg     <= '0;
      byp_data_reg <= '0;
    end else begin
      v1_reg <= rd_acc;
      if (rd_acc) begin
        bank_reg <= bank_sel;
        if (bypass_en_i) begin
          src_reg      <= SRC_BYP;
          byp_data_reg <= wdata_i;
        end else begin
          src_reg <= SRC_RAM;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (src_reg)
      SRC_RAM: rd_data = cell_rdata[bank_reg];
      SRC_BYP: rd_data = byp_data_reg;
      default: rd_data = '0;
    endcase
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
      if (rst_i) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= v1_reg;
        if (v1_reg) begin
          rdata_reg <= rd_data;
        end
      end
    end

    assign rvalid_o = rvalid_reg;
    assign rdata_o  = rdata_reg;
  end else begin : g_out_comb
    assign rvalid_o = v1_reg;
    assign rdata_o  = rd_data;
  end

endmodule

// File: tb/tb_sp_ram_banked_wrap.sv
// Self-checking bench for sp_ram_banked_wrap: scoreboard of expected read
// returns (data and arrival cycle) plus per-scenario inline checks.
module tb_sp_ram_banked_wrap;

  localparam int NW   = 64;
  localparam int NB   = 4;
  localparam int DW   = 32;
  localparam int AW   = 6;
  localparam int OREG = 0;
  localparam int LAT  = (OREG != 0) ? 2 : 1;
  localparam int ROWS = NW / NB;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_i = 1'b0;
  logic          gnt_o;
  logic [AW-1:0] addr_i = '0;
  logic          we_i = 1'b0;
  logic [3:0]    be_i = '0;
  logic [DW-1:0] wdata_i = '0;
  logic          bypass_en_i = 1'b0;
  logic          rvalid_o;
  logic [DW-1:0] rdata_o;
  logic          init_busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];

  sp_ram_banked_wrap #(
    .NUM_WORDS     (NW),
    .DATA_WIDTH    (DW),
    .NUM_BANKS     (NB),
    .OUT_REG       (OREG),
    .INIT_ON_RESET (1)
  ) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .bypass_en_i (bypass_en_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .init_busy_o (init_busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every rvalid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rvalid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected cyc %0d got rdata %h want no rvalid", cyc, rdata_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rdata_o !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL read_return addr %h got %h at cyc %0d want %h at cyc %0d",
                   e.addr, rdata_o, cyc, e.data, e.cyc);
        end else begin
          $display("txn read addr %h rdata %h cyc %0d", e.addr, rdata_o, cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic access(input logic w, input logic [AW-1:0] a, input logic [3:0] b,
                        input logic [DW-1:0] d, input logic byp, input logic [DW-1:0] expd);
    @(posedge clk);
    #1;
    req_i = 1'b1; we_i = w; addr_i = a; be_i = b; wdata_i = d; bypass_en_i = byp;
    if (!w || byp) begin
      exp_t e;
      e.data = expd; e.cyc = cyc + LAT; e.addr = a;
      exp_q.push_back(e);
    end else begin
      $display("txn write addr %h data %h be %h", a, d, b);
    end
    #1;
    checks++;
    if (gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL gnt addr %h got %b want 1", a, gnt_o);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      req_i = 1'b0; we_i = 1'b0; bypass_en_i = 1'b0;
    end
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d outstanding reads want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Counts init_busy_o cycles from now; req_i stays as driven by the caller.
  task automatic wait_init();
    int n = 0;
    bit gnt_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (init_busy_o !== 1'b1) break;
      n++;
      if (gnt_o !== 1'b0) gnt_bad = 1;
    end
    req_i = 1'b0;
    checks++;
    if (n != ROWS) begin
      errors++;
      $display("FAIL init_len got %0d cycles want %0d", n, ROWS);
    end
    checks++;
    if (gnt_bad) begin
      errors++;
      $display("FAIL init_gnt got gnt_o=1 during init want 0");
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b want 0", gnt_o); end
    checks++;
    if (rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", rvalid_o); end
    checks++;
    if (rdata_o !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
    checks++;
    if (init_busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", init_busy_o); end
    rst_i = 1'b0;
    wait_init();
    for (int a = 0; a < NW; a++) access(1'b0, AW'(a), 4'h0, '0, 1'b0, 32'h0);
    drain();
  endtask

  task automatic test_byte_enable();
    access(1'b1, 6'h05, 4'hF, 32'hDEADBEEF, 1'b0, '0);
    access(1'b1, 6'h05, 4'h5, 32'h11223344, 1'b0, '0);
    access(1'b0, 6'h05, 4'h0, '0, 1'b0, 32'hDE22BE44);
    access(1'b1, 6'h05, 4'h0, 32'hFFFFFFFF, 1'b0, '0);
    access(1'b0, 6'h05, 4'h0, '0, 1'b0, 32'hDE22BE44);
    drain();
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 8; i++) access(1'b1, AW'(i), 4'hF, 32'(i) * 32'h01010101, 1'b0, '0);
    for (int i = 0; i < 8; i++) access(1'b0, AW'(i), 4'h0, '0, 1'b0, 32'(i) * 32'h01010101);
    drain();
  endtask

  task automatic test_bypass();
    access(1'b1, 6'h10, 4'hF, 32'hA5A5A5A5, 1'b0, '0);
    access(1'b1, 6'h10, 4'hF, 32'h12345678, 1'b1, 32'h12345678);
    access(1'b0, 6'h11, 4'h0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D);
    access(1'b0, 6'h10, 4'h0, '0, 1'b0, 32'hA5A5A5A5);
    drain();
    idle(3);
    checks++;
    if (rvalid_o !== 1'b0 || rdata_o !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL rdata_hold got rvalid %b rdata %h want 0 a5a5a5a5", rvalid_o, rdata_o);
    end
  endtask

  task automatic test_reset_mid_read();
    access(1'b0, 6'h10, 4'h0, '0, 1'b0, 32'hA5A5A5A5);
    @(posedge clk);
    #1;
    req_i = 1'b0; rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    checks++;
    if (rvalid_o !== 1'b0 || rdata_o !== '0) begin
      errors++;
      $display("FAIL mid_read_reset got rvalid %b rdata %h want 0 0", rvalid_o, rdata_o);
    end
    exp_q.delete();
    wait_init();
  endtask

  task automatic test_reset_mid_init();
    @(posedge clk);
    #1;
    rst_i = 1'b1; req_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    wait_init();
    access(1'b0, 6'h05, 4'h0, '0, 1'b0, 32'h0);
    access(1'b0, 6'h10, 4'h0, '0, 1'b0, 32'h0);
    access(1'b0, 6'h3F, 4'h0, '0, 1'b0, 32'h0);
    drain();
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_interleave();
    test_bypass();
    test_reset_mid_read();
    test_reset_mid_init();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sp_ram_banked_wrap.md
Name: sp_ram_banked_wrap

Overview:
Parametrised next-generation single-port RAM wrapper for core instruction/data memories. It provides configurable data width, depth and word-interleaved bank count, and a req/gnt/rvalid handshake. It adds a post-reset zero-initialisation FSM, an optional output register, and RAM bypass (write data forwarded to the read port, write suppressed). It sits between the core/AXI memory adapters and the technology RAM cells.

Parameters:
NUM_WORDS, 32768, total depth in DATA_WIDTH words; power of two.
DATA_WIDTH, 32, word width; multiple of 8.
NUM_BANKS, 4, word-interleaved banks; power of two, at most NUM_WORDS.
ADDR_WIDTH, $clog2(NUM_WORDS), word address width.
BE_WIDTH, DATA_WIDTH/8, byte-enable width.
OUT_REG, 0, 1 = extra output register stage (+1 read latency).
INIT_ON_RESET, 1, 1 = zero all words after reset before granting.

Ports:
clk  in  1  clock
rst_i  in  1  synchronous active-high reset
req_i  in  1  access request
gnt_o  out  1  request accepted this cycle
addr_i  in  ADDR_WIDTH  word address
we_i  in  1  1 = write, 0 = read
be_i  in  BE_WIDTH  byte enables (writes only)
wdata_i  in  DATA_WIDTH  write data
bypass_en_i  in  1  bypass mode
rvalid_o  out  1  read data valid
rdata_o  out  DATA_WIDTH  read data
init_busy_o  out  1  initialisation in progress

Behaviour:
- Reset (rst_i high at a clk edge): gnt_o=0, rvalid_o=0, rdata_o=0, init_busy_o=INIT_ON_RESET, FSM enters INIT (or READY if INIT_ON_RESET=0), init counter=0. RAM contents are not touched by reset itself.
- FSM states are INIT and READY.
- INIT: each cycle writes all-zero, full byte enables, at row init_cnt in every bank in parallel. init_cnt counts 0..NUM_WORDS/NUM_BANKS-1. After the last row, the FSM moves to READY and init_busy_o falls the same edge. Total INIT is NUM_WORDS/NUM_BANKS cycles. gnt_o=0 throughout and req_i is ignored.
- READY: gnt_o = req_i (combinational). One access per cycle; no back-pressure.
- Bank select is addr_i[$clog2(NUM_BANKS)-1:0]; row is the upper bits. Only the selected bank is enabled.
- Write (req&gnt&we, bypass_en_i=0): each byte b with be_i[b]=1 is written. be_i=0 is a legal no-op write. Writes never raise rvalid_o.
- Read (req&gnt&!we): rvalid_o=1 and rdata_o=word exactly 1 cycle later (2 if OUT_REG=1). rvalid_o is a single-cycle pulse per read. rdata_o holds its last value when rvalid_o=0.
- Bank index is registered alongside the request and drives the read mux. Back-to-back reads to different banks return in order, one per cycle.
- Bypass (req&gnt&bypass_en_i): the RAM write enable is forced low for every bank. Read and write both return wdata_i with rvalid_o after the normal read latency. be_i is ignored. The RAM is unchanged.
- Read-after-write, same address, consecutive cycles: the read returns the newly written data. This needs no forwarding because the write completes at the first edge.
- Reset mid-INIT or mid-read: the FSM restarts INIT from row 0 and any in-flight rvalid is dropped (rvalid_o=0 next cycle).
- Elaboration error if NUM_WORDS%NUM_BANKS!=0, DATA_WIDTH%8!=0, or NUM_BANKS is not a power of two.

Decomposition:
- sp_ram_pkg holds the FSM state typedef (INIT/READY) and a bank-index width function.
- One sub-module, sp_ram_be_cell: single bank, DATA_WIDTH x NUM_WORDS/NUM_BANKS, synchronous read, per-byte write enables, 1-cycle latency.
- The wrapper generates NUM_BANKS instances of it and contains the FSM, init counter, bank mux and optional output register.

Test Plan:
- Init: reset with NUM_WORDS=64, NUM_BANKS=4 -> init_busy_o high exactly 16 cycles, gnt_o=0 throughout; then read all 64 addresses -> every word reads 0.
- Byte enables: write 0xDEADBEEF to 0x05 with be=0xF, then 0x11223344 with be=0x5 -> read 0x05 returns 0xDE22BE44, rvalid 1 cycle after gnt (2 with OUT_REG=1).
- Interleave: write addr i with data i*0x01010101 for i=0..7, then 8 back-to-back reads -> 8 consecutive rvalid pulses, in order, correct data, no gaps.
- Bypass: addr 0x10 holds 0xA5A5A5A5; bypass write 0x12345678 to 0x10 -> rvalid with rdata 0x12345678; normal read of 0x10 -> 0xA5A5A5A5.
- Reset mid-INIT: assert rst_i at init cycle 7 -> init restarts from row 0, full 16-cycle INIT, no rvalid; req_i held high during INIT is never granted.
- Reset mid-read: issue read, assert rst_i next cycle -> rvalid_o stays 0 and rdata_o=0 after the reset edge.
